// File: rtl/id_decode_queue_pkg.sv
// Shared definitions for the decode queue: opcode constants, the memory
// size enum, immediate-format select, the packed decoded-control struct and
// the control decode function.
// Optional feature macro: ID_DECODE_ATOMIC_EN (decode of the AMO opcode, which
// only covers lr/sc-style word and double accesses).
package common;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_AMO       = 7'b0101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [1:0] {
    MEM_BYTE   = 2'b00,
    MEM_HALF   = 2'b01,
    MEM_WORD   = 2'b10,
    MEM_DOUBLE = 2'b11
  } mem_size_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_CSR_REG,
    IMM_CSR_UIMM
  } imm_sel_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      alu_src;
    logic      mem_to_reg;
    logic      illegal;
    mem_size_e mem_size;
    imm_sel_e  imm_sel;
  } ctrl_t;

  // Anything illegal collapses to illegal=1 with every other field zero,
  // including imm_sel, so the immediate reads as zero.
  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode,
                                        input logic [2:0] funct3,
                                        input logic       rv32);
    ctrl_t c;
    c = '0;
    case (opcode)
      OPC_OP, OPC_OP_32: c.reg_write = 1'b1;
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.imm_sel   = IMM_I;
      end
      OPC_LUI, OPC_AUIPC: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.imm_sel   = IMM_U;
      end
      OPC_LOAD: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.imm_sel    = IMM_I;
        c.mem_size   = mem_size_e'(funct3[1:0]);
        c.illegal    = rv32 && (funct3[1:0] == 2'b11);
      end
      OPC_STORE: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.imm_sel   = IMM_S;
        c.mem_size  = mem_size_e'(funct3[1:0]);
        c.illegal   = rv32 && (funct3[1:0] == 2'b11);
      end
      OPC_BRANCH: begin
        c.branch  = 1'b1;
        c.imm_sel = IMM_B;
      end
      OPC_JAL: begin
        c.reg_write = 1'b1;
        c.branch    = 1'b1;
        c.alu_src   = 1'b1;
        c.imm_sel   = IMM_J;
      end
      OPC_JALR: begin
        c.reg_write = 1'b1;
        c.branch    = 1'b1;
        c.alu_src   = 1'b1;
        c.imm_sel   = IMM_I;
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b100) begin
          c.illegal = 1'b1;
        end else if (funct3 != 3'b000) begin
          c.reg_write = 1'b1;
          c.alu_src   = 1'b1;
          c.imm_sel   = funct3[2] ? IMM_CSR_UIMM : IMM_CSR_REG;
        end
      end
`ifdef ID_DECODE_ATOMIC_EN
      OPC_AMO: begin
        if (funct3 == 3'b010 || (funct3 == 3'b011 && !rv32)) begin
          c.reg_write = 1'b1;
          c.mem_read  = 1'b1;
          c.mem_write = 1'b1;
          c.alu_src   = 1'b1;
          c.mem_size  = mem_size_e'(funct3[1:0]);
        end else begin
          c.illegal = 1'b1;
        end
      end
`endif
      default: c.illegal = 1'b1;
    endcase
    if (c.illegal) begin
      c         = '0;
      c.illegal = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/id_imm_gen.sv
// Combinational immediate generator: builds the selected RV immediate from
// the instruction bits above the opcode and extends it to XLEN.
module id_imm_gen
  import common::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:7]     instr,
  input  imm_sel_e        sel,
  output logic [XLEN-1:0] imm
);

  // Sign-extended formats are assembled as signed 32-bit values first.
  always_comb begin
    imm = '0;
    case (sel)
      IMM_I: imm = XLEN'(signed'({{20{instr[31]}}, instr[31:20]}));
      IMM_S: imm = XLEN'(signed'({{20{instr[31]}}, instr[31:25], instr[11:7]}));
      IMM_B: imm = XLEN'(signed'({{19{instr[31]}}, instr[31], instr[7],
                                  instr[30:25], instr[11:8], 1'b0}));
      IMM_U: imm = XLEN'(signed'({instr[31:12], 12'b0}));
      IMM_J: imm = XLEN'(signed'({{11{instr[31]}}, instr[31], instr[19:12],
                                  instr[20], instr[30:21], 1'b0}));
      IMM_CSR_REG:  imm = XLEN'(instr[31:20]);
      IMM_CSR_UIMM: imm = XLEN'(instr[19:15]);
      default:      imm = '0;
    endcase
  end

endmodule

// File: rtl/id_decode_queue.sv
// Decode stage with a small decoded-entry queue between fetch and execute.
// Instructions are decoded combinationally on the way in and stored as a
// packed control struct plus pc/instr; the immediate is rebuilt from the
// head entry's instruction bits.
// Optional feature macro: ID_DECODE_ATOMIC_EN (see package common).
module id_decode_queue
  import common::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [4:0]               rd,
  output logic [XLEN-1:0]          imm,
  output logic [1:0]               mem_size,
  output logic                     reg_write,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     branch,
  output logic                     alu_src,
  output logic                     mem_to_reg,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int  PW   = $clog2(DEPTH);
  localparam logic RV32 = (XLEN == 32);

  ctrl_t           ctrl_mem  [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  ctrl_t           in_ctrl;
  ctrl_t           head_ctrl;
  logic            push;
  logic            pop;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready depends only on occupancy (never on out_ready), so a
  // full queue refuses a push even in a cycle that pops. flush overrides both
  // sides: nothing is pushed or popped in a flush cycle.
  assign in_ready  = (count != (PW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign in_ctrl   = decode_ctrl(in_instr[6:0], in_instr[14:12], RV32);

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage, written at the tail on each accepted push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_mem[i]  <= '0;
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      ctrl_mem[tail]  <= in_ctrl;
      pc_mem[tail]    <= in_pc;
      instr_mem[tail] <= in_instr;
    end
  end

  assign head_ctrl = ctrl_mem[head];
  assign out_pc    = pc_mem[head];
  assign out_instr = instr_mem[head];
  assign rs1       = out_instr[19:15];
  assign rs2       = out_instr[24:20];
  assign rd        = out_instr[11:7];

  // Control outputs are forced low whenever no entry is presented.
  always_comb begin
    reg_write  = out_valid & head_ctrl.reg_write;
    mem_read   = out_valid & head_ctrl.mem_read;
    mem_write  = out_valid & head_ctrl.mem_write;
    branch     = out_valid & head_ctrl.branch;
    alu_src    = out_valid & head_ctrl.alu_src;
    mem_to_reg = out_valid & head_ctrl.mem_to_reg;
    illegal    = out_valid & head_ctrl.illegal;
    mem_size   = out_valid ? head_ctrl.mem_size : MEM_BYTE;
  end

  id_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr (out_instr[31:7]),
    .sel   (head_ctrl.imm_sel),
    .imm   (imm)
  );

endmodule

// File: tb/tb_id_decode_queue.sv
// Bench for id_decode_queue (default XLEN=64, DEPTH=2): directed scenarios
// plus a randomized run checked against a queue-based reference model.
module tb_id_decode_queue;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [5:0]  code;
    logic        ill;
    logic [1:0]  ms;
    logic [63:0] imm;
  } dec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  rs1, rs2, rd;
  logic [63:0] imm;
  logic [1:0]  mem_size;
  logic        reg_write, mem_read, mem_write, branch, alu_src, mem_to_reg, illegal;
  logic [1:0]  count;

  logic [95:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  id_decode_queue dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .imm        (imm),
    .mem_size   (mem_size),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .branch     (branch),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .count      (count)
  );

  wire [5:0] code = {reg_write, mem_read, mem_write, branch, alu_src, mem_to_reg};

  // Reference decode written straight from the instruction-set tables.
  function automatic dec_t model_decode(input logic [31:0] i);
    dec_t        d;
    longint      si;
    logic [6:0]  op;
    logic [2:0]  f3;
    d  = '0;
    si = longint'(signed'(i));
    op = i[6:0];
    f3 = i[14:12];
    case (op)
      7'h33, 7'h3B: d.code = 6'b100000;
      7'h13, 7'h1B: begin d.code = 6'b100010; d.imm = si >>> 20; end
      7'h37, 7'h17: begin d.code = 6'b100010; d.imm = si & ~64'hFFF; end
      7'h03: begin d.code = 6'b110011; d.ms = f3[1:0]; d.imm = si >>> 20; end
      7'h23: begin
        d.code = 6'b001010; d.ms = f3[1:0];
        d.imm  = ((si >>> 25) <<< 5) | longint'(i[11:7]);
      end
      7'h63: begin
        d.code = 6'b000100;
        d.imm  = ((si >>> 31) <<< 12) | longint'({i[7], 11'b0})
               | longint'({i[30:25], 5'b0}) | longint'({i[11:8], 1'b0});
      end
      7'h6F: begin
        d.code = 6'b100110;
        d.imm  = ((si >>> 31) <<< 20) | longint'({i[19:12], 12'b0})
               | longint'({i[20], 11'b0}) | longint'({i[30:21], 1'b0});
      end
      7'h67: begin d.code = 6'b100110; d.imm = si >>> 20; end
      7'h73: begin
        if (f3 == 3'd4) d.ill = 1'b1;
        else if (f3 != 3'd0) begin
          d.code = 6'b100010;
          d.imm  = f3[2] ? longint'(i[19:15]) : longint'(i[31:20]);
        end
      end
`ifdef ID_DECODE_ATOMIC_EN
      7'h2F: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin d.code = 6'b111010; d.ms = f3[1:0]; end
        else d.ill = 1'b1;
      end
`endif
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [16];
    logic [31:0] r;
    ops = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h37, 7'h17, 7'h03, 7'h23,
            7'h63, 7'h6F, 7'h67, 7'h73, 7'h73, 7'h2F, 7'h7F, 7'h0B};
    r = $urandom();
    return {r[31:7], ops[$urandom_range(0, 15)]};
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Advance one edge and move the model along using the pre-edge inputs.
  task automatic tick();
    logic acc, ret, fl;
    logic [95:0] ent;
    fl  = flush;
    acc = in_valid && !flush && (exp_q.size() < DEPTH);
    ret = out_ready && !flush && (exp_q.size() > 0);
    ent = {in_pc, in_instr};
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
    else begin
      if (ret) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ent);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, out_valid, count} !== 4'b1000) begin
      errors++; $display("FAIL reset_status got=%b exp=1000", {in_ready, out_valid, count});
    end
    checks++;
    if ({code, illegal} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0", {code, illegal});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, '0, '0, 0, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_first_push();
    drive(1, 64'h8000_0000, 32'hFFF0_0093, 0, 0);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL first_pre_valid got=%b exp=0", out_valid); end
    tick();
    drive(0, '0, '0, 0, 0);
    #1;
    checks++;
    if ({out_valid, rd, count} !== {1'b1, 5'd1, 2'd1}) begin
      errors++; $display("FAIL first_head got=%b exp=%b", {out_valid, rd, count}, {1'b1, 5'd1, 2'd1});
    end
    checks++;
    if (imm !== 64'hFFFF_FFFF_FFFF_FFFF || out_pc !== 64'h8000_0000) begin
      errors++; $display("FAIL first_imm_pc got=%h/%h exp=ffffffffffffffff/80000000", imm, out_pc);
    end
    checks++;
    if ({code, illegal} !== 7'b100010_0) begin
      errors++; $display("FAIL first_code got=%b exp=1000100", {code, illegal});
    end
    drive(0, '0, '0, 1, 0);
    tick();
    checks++;
    if ({out_valid, count} !== 3'b000) begin
      errors++; $display("FAIL first_drain got=%b exp=000", {out_valid, count});
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 64'h100, 32'h0010_0113, 0, 0); tick();
    drive(1, 64'h104, 32'h0041_2183, 0, 0); tick();
    drive(1, 64'h108, 32'h0030_2423, 0, 0); #1;
    checks++;
    if ({in_ready, count, out_pc} !== {1'b0, 2'd2, 64'h100}) begin
      errors++; $display("FAIL b2b_full got=%b/%h exp=010/100", {in_ready, count}, out_pc);
    end
    tick();
    checks++;
    if ({count, out_pc} !== {2'd2, 64'h100}) begin
      errors++; $display("FAIL b2b_refused got=%0d/%h exp=2/100", count, out_pc);
    end
    // full queue with both sides active: pop happens, push is refused
    drive(1, 64'h108, 32'h0030_2423, 1, 0); #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got=%b exp=0", in_ready); end
    tick();
    checks++;
    if ({count, out_pc} !== {2'd1, 64'h104}) begin
      errors++; $display("FAIL full_pop_count got=%0d/%h exp=1/104", count, out_pc);
    end
    drive(1, 64'h108, 32'h0030_2423, 0, 0); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_reopen got=%b exp=1", in_ready); end
    tick();
    drive(0, '0, '0, 1, 0); #1;
    checks++;
    if ({count, out_pc, code, mem_size, imm} !== {2'd2, 64'h104, 6'b110011, 2'b10, 64'd4}) begin
      errors++; $display("FAIL b2b_load got=%0d/%h/%b/%b/%h exp=2/104/110011/10/4", count, out_pc, code, mem_size, imm);
    end
    tick();
    checks++;
    if ({out_pc, code, mem_size, imm} !== {64'h108, 6'b001010, 2'b10, 64'd8}) begin
      errors++; $display("FAIL b2b_store got=%h/%b/%b/%h exp=108/001010/10/8", out_pc, code, mem_size, imm);
    end
    tick();
    checks++;
    if (count !== 2'd0) begin errors++; $display("FAIL b2b_empty got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    drive(1, 64'h200, 32'h0010_0113, 0, 0); tick();
    drive(1, 64'h204, 32'h0041_2183, 0, 0); tick();
    drive(1, 64'h208, 32'h0030_2423, 1, 1); tick();
    drive(0, '0, '0, 1, 0); #1;
    checks++;
    if ({in_ready, out_valid, count, code, illegal} !== {1'b1, 1'b0, 2'd0, 7'b0}) begin
      errors++; $display("FAIL flush_state got=%b exp=10000000000", {in_ready, out_valid, count, code, illegal});
    end
    drive(1, 64'h300, 32'h0000_006F, 0, 0); tick();
    drive(0, '0, '0, 1, 0); #1;
    checks++;
    if ({count, out_pc, code} !== {2'd1, 64'h300, 6'b100110}) begin
      errors++; $display("FAIL flush_refill got=%0d/%h/%b exp=1/300/100110", count, out_pc, code);
    end
    tick();
  endtask

  task automatic test_atomic();
    drive(1, 64'h400, 32'h1000_A52F, 0, 0); tick();
    drive(0, '0, '0, 1, 0); #1;
`ifdef ID_DECODE_ATOMIC_EN
    checks++;
    if ({code, illegal, mem_size} !== {6'b111010, 1'b0, 2'b10}) begin
      errors++; $display("FAIL atomic_lrw got=%b exp=111010010", {code, illegal, mem_size});
    end
`else
    checks++;
    if ({code, illegal} !== {6'b000000, 1'b1}) begin
      errors++; $display("FAIL atomic_lrw got=%b exp=0000001", {code, illegal});
    end
`endif
    tick();
  endtask

  task automatic test_async_reset();
    drive(1, 64'h500, 32'h0010_0113, 0, 0); tick();
    drive(1, 64'h504, 32'h0041_2183, 0, 0); tick();
    drive(0, '0, '0, 0, 0);
    #3;
    reset = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if ({in_ready, out_valid, count} !== 4'b1000) begin
      errors++; $display("FAIL async_reset got=%b exp=1000", {in_ready, out_valid, count});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, '0, '0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({out_valid, count} !== 3'b000) begin
        errors++; $display("FAIL async_release cyc=%0d got=%b exp=000", k, {out_valid, count});
      end
      tick();
    end
  endtask

  task automatic test_random();
    int          n;
    dec_t        m;
    logic [95:0] hd;
    logic [31:0] hi;
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, {$urandom(), $urandom()}, rand_instr(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      #1;
      n = exp_q.size();
      checks++;
      if ({in_ready, out_valid, count} !== {n < DEPTH, n != 0, 2'(n)}) begin
        errors++; $display("FAIL rnd_status cyc=%0d got=%b exp=%b", k, {in_ready, out_valid, count}, {n < DEPTH, n != 0, 2'(n)});
      end
      if (n > 0) begin
        hd = exp_q[0];
        hi = hd[31:0];
        m  = model_decode(hi);
        checks++;
        if ({out_pc, out_instr, rd, rs1, rs2} !== {hd, hi[11:7], hi[19:15], hi[24:20]}) begin
          errors++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", k, out_pc, out_instr, hd[95:32], hi);
        end
        checks++;
        if ({code, illegal, mem_size, imm} !== {m.code, m.ill, m.ms, m.imm}) begin
          errors++; $display("FAIL rnd_decode cyc=%0d instr=%h got=%b/%b/%b/%h exp=%b/%b/%b/%h",
                             k, hi, code, illegal, mem_size, imm, m.code, m.ill, m.ms, m.imm);
        end
      end else begin
        checks++;
        if ({code, illegal} !== 7'b0) begin
          errors++; $display("FAIL rnd_idle_ctrl cyc=%0d got=%b exp=0", k, {code, illegal});
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_back_to_back();
    test_flush();
    test_atomic();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
